// File: rtl/shared_reg_arb_pkg.sv
// shared_reg_arb_pkg: FSM state encoding and round-robin pick helper for shared_reg_arbiter
package shared_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } state_e;

  localparam int MAX_N = 16;

  // Scanning downward leaves the lowest offset from ptr as the final winner.
  function automatic logic [3:0] rr_pick(input logic [MAX_N-1:0] req, input logic [3:0] ptr, input int n);
    logic [3:0] w;
    int i;
    w = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      i = int'(ptr) + k;
      if (i >= n) i = i - n;
      if (req[i]) w = i[3:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_dff_en_vec.sv
// dff_en_vec: W-bit enabled flop bank with asynchronous active-low reset to zero
module dff_en_vec #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of one shared W-bit register, one write per grant.
// Optional SHARED_REG_LOCK_EN adds a lock input letting the current owner keep the register.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [W-1:0]   q
);

  localparam int PTR_W = $clog2(N);

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q, idx_q, win, pick, nxt_ptr;
  logic [N-1:0]     gnt_q, ack_q;
  logic             busy_q, en, adv;
  logic [W-1:0]     d;

  assign win     = PTR_W'(rr_pick(MAX_N'(req), 4'(ptr_q), N));
  assign nxt_ptr = (int'(idx_q) == N - 1) ? '0 : idx_q + PTR_W'(1);
  assign en      = state_q == WRITE;
  assign d       = wdata[idx_q*W +: W];

`ifdef SHARED_REG_LOCK_EN
  logic lock_own_q, hold;
  assign hold = lock_own_q && req[idx_q];
  assign pick = hold ? idx_q : win;
  assign adv  = !lock[idx_q];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock_own_q <= 1'b0;
    else if (state_q == IDLE) lock_own_q <= hold;
    else if (state_q == ACK) lock_own_q <= lock[idx_q];
  end
`else
  assign pick = win;
  assign adv  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req != '0) begin
          state_q <= WRITE;
          idx_q   <= pick;
          gnt_q   <= N'(1) << pick;
          busy_q  <= 1'b1;
        end
        WRITE: begin
          state_q <= ACK;
          ack_q   <= N'(1) << idx_q;
        end
        ACK: begin
          state_q <= IDLE;
          if (adv) ptr_q <= nxt_ptr;
          gnt_q   <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  dff_en_vec #(.W(W)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .q   (q)
  );

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule
